riscv_mc_ctrl: RTL and testbench

Main control FSM for the multicycle RISC-V core. It sequences one shared ALU, one unified instruction/data memory port and the register file across states.
- Decodes op[6:0] into a state sequence.
- Drives the aluop code consumed by the ALU decoder, plus datapath mux selects and write strobes.
- Sits between the instruction register and the datapath; it replaces the single-cycle main decoder.

---
 rtl/riscv_mc_ctrl_pkg.sv | 66 ++++++
 rtl/riscv_mc_ctrl_if.sv | 35 +++
 rtl/riscv_mc_ctrl_outdec.sv | 103 ++++++++++
 rtl/riscv_mc_ctrl.sv | 97 +++++++++
 tb/tb_riscv_mc_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V main control FSM.
// Optional memory wait states are enabled by MC_CTRL_MEMWAIT_EN (see riscv_mc_ctrl.sv).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALUOP_ITYPE = 3'b000;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Control-to-datapath bundle for riscv_mc_ctrl; memready exists only with MC_CTRL_MEMWAIT_EN.
interface riscv_mc_ctrl_if;
  logic [6:0] op;
  logic       eq;
`ifdef MC_CTRL_MEMWAIT_EN
  logic       memready;
`endif
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluop;
  logic       illegal;
  logic       halted;

`ifdef MC_CTRL_MEMWAIT_EN
  modport master (output op, eq, memready,
                  input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, aluop, illegal, halted);
  modport slave  (input  op, eq, memready,
                  output pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, aluop, illegal, halted);
`else
  modport master (output op, eq,
                  input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, aluop, illegal, halted);
  modport slave  (input  op, eq,
                  output pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, aluop, illegal, halted);
`endif
endinterface

// File: rtl/riscv_mc_ctrl_outdec.sv
// State-to-controls decoder: Moore outputs plus eq/memready strobe gating and reset masking.
// memready gating is present only when MC_CTRL_MEMWAIT_EN is defined.
module mc_ctrl_outdec
  import riscv_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] op_i,
  input  logic       eq_i,
  input  logic       reset_i,
`ifdef MC_CTRL_MEMWAIT_EN
  input  logic       memready_i,
`endif
  output ctrl_t      ctrl_o
);

  logic ready_s;

`ifdef MC_CTRL_MEMWAIT_EN
  assign ready_s = memready_i;
`else
  assign ready_s = 1'b1;
`endif

  // Per-state control decode; write strobes are suppressed while reset is held.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.pcwrite   = ready_s;
        ctrl_o.irwrite   = ready_s;
        ctrl_o.adrsrc    = 1'b0;
        ctrl_o.alusrca   = SRCA_PC;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.aluop     = ALUOP_ADD;
        ctrl_o.resultsrc = RES_ALURES;
      end
      DECODE: begin
        ctrl_o.alusrca = SRCA_OLDPC;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.illegal = ~op_supported(op_i);
      end
      MEMADR: begin
        ctrl_o.alusrca = SRCA_RS1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl_o.adrsrc    = 1'b1;
        ctrl_o.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl_o.resultsrc = RES_MEMDATA;
        ctrl_o.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl_o.adrsrc   = 1'b1;
        ctrl_o.memwrite = ready_s;
      end
      EXECR: begin
        ctrl_o.alusrca = SRCA_RS1;
        ctrl_o.alusrcb = SRCB_RS2;
        ctrl_o.aluop   = ALUOP_RTYPE;
      end
      EXECI: begin
        ctrl_o.alusrca = SRCA_RS1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ITYPE;
      end
      ALUWB: begin
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.regwrite  = 1'b1;
      end
      BEQ: begin
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.pcwrite   = eq_i;
      end
      JAL: begin
        ctrl_o.alusrca   = SRCA_OLDPC;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.aluop     = ALUOP_ADD;
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.pcwrite   = 1'b1;
      end
      HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
    if (reset_i) begin
      ctrl_o.pcwrite  = 1'b0;
      ctrl_o.memwrite = 1'b0;
      ctrl_o.irwrite  = 1'b0;
      ctrl_o.regwrite = 1'b0;
      ctrl_o.illegal  = 1'b0;
    end else begin
      ctrl_o.halted = ctrl_o.halted;
    end
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Main control FSM of the multicycle RISC-V core: state register and next-state logic.
// Define MC_CTRL_MEMWAIT_EN to stall FETCH/MEMREAD/MEMWRITE until memready.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  riscv_mc_ctrl_if.slave  bus
);

  state_t state_q;
  state_t state_d;
  logic   ready_s;
  ctrl_t  ctrl_s;

`ifdef MC_CTRL_MEMWAIT_EN
  assign ready_s = bus.memready;
`else
  assign ready_s = 1'b1;
`endif

  // Next-state selection; op is consulted only in DECODE and (bit 5) in MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (ready_s) state_d = DECODE;
        else         state_d = FETCH;
      end
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BEQ:            state_d = BEQ;
          OP_JAL:            state_d = JAL;
          default: begin
            if (ILLEGAL_HALT) state_d = HALT;
            else              state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        if (bus.op[5]) state_d = MEMWRITE;
        else           state_d = MEMREAD;
      end
      MEMREAD: begin
        if (ready_s) state_d = MEMWB;
        else         state_d = MEMREAD;
      end
      MEMWRITE: begin
        if (ready_s) state_d = FETCH;
        else         state_d = MEMWRITE;
      end
      MEMWB:   state_d = FETCH;
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BEQ:     state_d = FETCH;
      JAL:     state_d = ALUWB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State register; reset forces FETCH immediately from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  mc_ctrl_outdec u_outdec (
    .state_i    (state_q),
    .op_i       (bus.op),
    .eq_i       (bus.eq),
    .reset_i    (reset),
`ifdef MC_CTRL_MEMWAIT_EN
    .memready_i (bus.memready),
`endif
    .ctrl_o     (ctrl_s)
  );

  assign bus.pcwrite   = ctrl_s.pcwrite;
  assign bus.adrsrc    = ctrl_s.adrsrc;
  assign bus.memwrite  = ctrl_s.memwrite;
  assign bus.irwrite   = ctrl_s.irwrite;
  assign bus.regwrite  = ctrl_s.regwrite;
  assign bus.resultsrc = ctrl_s.resultsrc;
  assign bus.alusrca   = ctrl_s.alusrca;
  assign bus.alusrcb   = ctrl_s.alusrcb;
  assign bus.aluop     = ctrl_s.aluop;
  assign bus.illegal   = ctrl_s.illegal;
  assign bus.halted    = ctrl_s.halted;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed table-driven bench for riscv_mc_ctrl (ILLEGAL_HALT=0 and =1 instances).
module tb_riscv_mc_ctrl;

  // Expected control word: pc,adr,mw,ir,rw,resultsrc,alusrca,alusrcb,aluop,illegal,halted
  localparam logic [15:0] E_FETCH    = 16'b1_0_0_1_0_10_00_10_100_0_0;
  localparam logic [15:0] E_NOSTRB   = 16'b0_0_0_0_0_10_00_10_100_0_0;
  localparam logic [15:0] E_DECODE   = 16'b0_0_0_0_0_00_01_01_100_0_0;
  localparam logic [15:0] E_DEC_ILL  = 16'b0_0_0_0_0_00_01_01_100_1_0;
  localparam logic [15:0] E_MEMADR   = 16'b0_0_0_0_0_00_10_01_100_0_0;
  localparam logic [15:0] E_MEMREAD  = 16'b0_1_0_0_0_00_00_00_000_0_0;
  localparam logic [15:0] E_MEMWB    = 16'b0_0_0_0_1_01_00_00_000_0_0;
  localparam logic [15:0] E_MEMWRITE = 16'b0_1_1_0_0_00_00_00_000_0_0;
  localparam logic [15:0] E_EXECR    = 16'b0_0_0_0_0_00_10_00_010_0_0;
  localparam logic [15:0] E_EXECI    = 16'b0_0_0_0_0_00_10_01_000_0_0;
  localparam logic [15:0] E_ALUWB    = 16'b0_0_0_0_1_00_00_00_000_0_0;
  localparam logic [15:0] E_BEQ_T    = 16'b1_0_0_0_0_00_00_00_000_0_0;
  localparam logic [15:0] E_BEQ_N    = 16'b0_0_0_0_0_00_00_00_000_0_0;
  localparam logic [15:0] E_JAL      = 16'b1_0_0_0_0_00_01_10_100_0_0;
  localparam logic [15:0] E_HALT     = 16'b0_0_0_0_0_00_00_00_000_0_1;

  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;
  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] B = 7'b1100011;
  localparam logic [6:0] J = 7'b1101111;
  localparam logic [6:0] X = 7'b1111111;

  typedef struct packed {
    logic [6:0]  op;
    logic        eq;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [40];
  int   nv;
  int   checks;
  int   errors;

  logic clk;
  logic rst0;
  logic rst1;

  riscv_mc_ctrl_if bus0 ();
  riscv_mc_ctrl_if bus1 ();

  riscv_mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  riscv_mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  logic [15:0] act0;
  logic [15:0] act1;
  assign act0 = {bus0.pcwrite, bus0.adrsrc, bus0.memwrite, bus0.irwrite, bus0.regwrite,
                 bus0.resultsrc, bus0.alusrca, bus0.alusrcb, bus0.aluop, bus0.illegal, bus0.halted};
  assign act1 = {bus1.pcwrite, bus1.adrsrc, bus1.memwrite, bus1.irwrite, bus1.regwrite,
                 bus1.resultsrc, bus1.alusrca, bus1.alusrcb, bus1.aluop, bus1.illegal, bus1.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic eq, input logic [15:0] exp);
    vecs[nv] = '{op: op, eq: eq, exp: exp};
    nv++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nv     = 0;

    add(L, 1'b0, E_FETCH); add(L, 1'b0, E_DECODE); add(L, 1'b0, E_MEMADR);
    add(L, 1'b0, E_MEMREAD); add(L, 1'b0, E_MEMWB);
    // op changes after DECODE must not redirect the R-type path
    add(R, 1'b1, E_FETCH); add(R, 1'b1, E_DECODE); add(L, 1'b1, E_EXECR); add(X, 1'b1, E_ALUWB);
    add(I, 1'b0, E_FETCH); add(I, 1'b0, E_DECODE); add(I, 1'b0, E_EXECI); add(I, 1'b0, E_ALUWB);
    add(B, 1'b1, E_FETCH); add(B, 1'b1, E_DECODE); add(B, 1'b1, E_BEQ_T);
    add(B, 1'b0, E_FETCH); add(B, 1'b0, E_DECODE); add(B, 1'b0, E_BEQ_N);
    add(S, 1'b1, E_FETCH); add(S, 1'b1, E_DECODE); add(S, 1'b1, E_MEMADR); add(S, 1'b1, E_MEMWRITE);
    add(J, 1'b0, E_FETCH); add(J, 1'b0, E_DECODE); add(J, 1'b0, E_JAL); add(J, 1'b0, E_ALUWB);
    add(X, 1'b0, E_FETCH); add(X, 1'b0, E_DEC_ILL); add(X, 1'b0, E_FETCH);
    add(L, 1'b0, E_DECODE);

    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.op = L;
    bus0.eq = 1'b0;
    bus1.op = X;
    bus1.eq = 1'b0;
`ifdef MC_CTRL_MEMWAIT_EN
    bus0.memready = 1'b1;
    bus1.memready = 1'b1;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold_dut0", act0, E_NOSTRB);
    check("reset_hold_dut1", act1, E_NOSTRB);

    // Walk a load into MEMADR, then hit reset asynchronously there
    rst0 = 1'b0;
    #1 check("pre_fetch", act0, E_FETCH);
    @(negedge clk);
    #1 check("pre_decode", act0, E_DECODE);
    @(negedge clk);
    #1 check("pre_memadr", act0, E_MEMADR);
    rst0 = 1'b1;
    #1 check("async_reset_mid_memadr", act0, E_NOSTRB);
    @(negedge clk);
    #1 check("reset_held_fetch", act0, E_NOSTRB);
    rst0 = 1'b0;

    for (int i = 0; i < nv; i++) begin
      bus0.op = vecs[i].op;
      bus0.eq = vecs[i].eq;
      #1 check($sformatf("vec%0d", i), act0, vecs[i].exp);
      @(negedge clk);
    end

    // ILLEGAL_HALT=1: illegal opcode locks into HALT until reset
    rst1 = 1'b0;
    #1 check("halt_fetch", act1, E_FETCH);
    @(negedge clk);
    #1 check("halt_decode_illegal", act1, E_DEC_ILL);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus1.op = (k == 1) ? R : L;
      bus1.eq = 1'b1;
      #1 check($sformatf("halt_stay%0d", k), act1, E_HALT);
    end
    rst1 = 1'b1;
    #1 check("halt_reset", act1, E_NOSTRB);
    @(negedge clk);
    rst1 = 1'b0;
    #1 check("halt_release_fetch", act1, E_FETCH);
    @(negedge clk);
    #1 check("halt_release_decode", act1, E_DECODE);

`ifdef MC_CTRL_MEMWAIT_EN
    // FETCH stalls with strobes low until memready, then fires once
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    bus0.op = L;
    bus0.memready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("wait_fetch%0d", k), act0, E_NOSTRB);
      @(negedge clk);
    end
    bus0.memready = 1'b1;
    #1 check("wait_fetch_done", act0, E_FETCH);
    @(negedge clk);
    #1 check("wait_decode", act0, E_DECODE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
